// File: rtl/sram_arb_pkg.sv
// Shared definitions for the pixel SRAM arbiter: states, widths, pin encodings.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DFLT = 20;
  localparam int unsigned DATA_W_DFLT = 16;

  // Arbiter FSM states
  localparam int unsigned STATE_W     = 3;
  localparam logic [2:0]  ST_IDLE     = 3'd0;
  localparam logic [2:0]  ST_RD       = 3'd1;
  localparam logic [2:0]  ST_WR_SETUP = 3'd2;
  localparam logic [2:0]  ST_WR_PULSE = 3'd3;
  localparam logic [2:0]  ST_WR_HOLD  = 3'd4;

  // RGB565 field positions used by the scan-out logic
  localparam int unsigned RGB_B_LSB = 0;
  localparam int unsigned RGB_B_W   = 5;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_G_W   = 6;
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_R_W   = 5;

  // SRAM control pin set plus DQ output enable
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
    logic dq_oe;
  } sram_ctrl_t;

  localparam sram_ctrl_t CTRL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                       ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};

  // Pin pattern presented while the FSM sits in state st
  function automatic sram_ctrl_t ctrl_for_state(input logic [2:0] st, input logic [1:0] be);
    sram_ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      ST_RD:       c = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1,
                         ub_n: 1'b0, lb_n: 1'b0, dq_oe: 1'b0};
      ST_WR_SETUP,
      ST_WR_HOLD:  c = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                         ub_n: ~be[1], lb_n: ~be[0], dq_oe: 1'b1};
      ST_WR_PULSE: c = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0,
                         ub_n: ~be[1], lb_n: ~be[0], dq_oe: 1'b1};
      default:     c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram_pin_drv.sv
// Registered SRAM pin driver: address/control registers, DQ tristate and read capture.
module sram_pin_drv
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        state,
  input  logic [2:0]        state_nxt,
  input  logic              drive_nxt,
  input  logic              ld_addr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              ld_wr,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [1:0]        be_in,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic [1:0]        be_q;
  logic              drive_q;
  sram_ctrl_t        ctrl_q;
  logic [1:0]        be_nxt_c;
  sram_ctrl_t        ctrl_nxt_c;

  // Byte enables for the state being entered; a new write grant overrides the held value
  always_comb begin
    be_nxt_c   = ld_wr ? be_in : be_q;
    ctrl_nxt_c = ctrl_for_state(state_nxt, be_nxt_c);
  end

  // Address, write data and byte-enable latches loaded on a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      dout_q <= '0;
      be_q   <= '0;
    end else begin
      if (ld_addr) addr_q <= addr_in;
      if (ld_wr) begin
        dout_q <= wdata_in;
        be_q   <= be_in;
      end
    end
  end

  // Control pins and pin-ownership flag for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= CTRL_IDLE;
      drive_q <= 1'b1;
    end else begin
      ctrl_q  <= ctrl_nxt_c;
      drive_q <= drive_nxt;
    end
  end

  // Capture DQ at the end of each RD cycle and flag it the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= (state == ST_RD);
      if (state == ST_RD) rd_data <= SRAM_DQ;
    end
  end

  assign SRAM_ADDR = drive_q ? addr_q : {ADDR_W{1'bz}};
  assign SRAM_CE_N = drive_q ? ctrl_q.ce_n : 1'bz;
  assign SRAM_OE_N = drive_q ? ctrl_q.oe_n : 1'bz;
  assign SRAM_WE_N = drive_q ? ctrl_q.we_n : 1'bz;
  assign SRAM_UB_N = drive_q ? ctrl_q.ub_n : 1'bz;
  assign SRAM_LB_N = drive_q ? ctrl_q.lb_n : 1'bz;
  assign SRAM_DQ   = (drive_q && ctrl_q.dq_oe) ? dout_q : {DATA_W{1'bz}};

endmodule

// File: rtl/sram_arbiter.sv
// Pixel SRAM arbiter: display reads have priority, writes are protected by a starvation guard.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DFLT,
  parameter int unsigned DATA_W       = DATA_W_DFLT,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ready,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt_c;
  logic [CNT_W-1:0] starve_cnt;
  logic             decide_c;
  logic             wr_pri_c;
  logic             disp_gnt_c;
  logic             wr_gnt_c;
  logic             drive_nxt_c;

  // Grants are only possible in decision cycles while owning the bus and out of reset
  assign decide_c = !rst && enable &&
                    (state == ST_IDLE || state == ST_RD || state == ST_WR_HOLD);

  // Next-state and grant selection
  always_comb begin
    state_nxt_c = state;
    disp_gnt_c  = 1'b0;
    wr_gnt_c    = 1'b0;
    wr_pri_c    = (starve_cnt == CNT_W'(STARVE_LIMIT)) && wr_req;
    case (state)
      ST_WR_SETUP: state_nxt_c = ST_WR_PULSE;
      ST_WR_PULSE: state_nxt_c = ST_WR_HOLD;
      default: begin
        state_nxt_c = ST_IDLE;
        if (decide_c) begin
          if (wr_pri_c) begin
            wr_gnt_c    = 1'b1;
            state_nxt_c = ST_WR_SETUP;
          end else if (disp_req) begin
            disp_gnt_c  = 1'b1;
            state_nxt_c = ST_RD;
          end else if (wr_req) begin
            wr_gnt_c    = 1'b1;
            state_nxt_c = ST_WR_SETUP;
          end
        end
      end
    endcase
  end

  // Pins stay owned except when settling into IDLE with the bus released
  assign drive_nxt_c = !(state_nxt_c == ST_IDLE && !enable);

  assign disp_ready = disp_gnt_c;
  assign wr_ready   = wr_gnt_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt_c;
  end

  // Counts display grants that overtake a pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!wr_req || wr_gnt_c) begin
      starve_cnt <= '0;
    end else if (disp_gnt_c && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  sram_pin_drv #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pin_drv (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .state_nxt (state_nxt_c),
    .drive_nxt (drive_nxt_c),
    .ld_addr   (disp_gnt_c || wr_gnt_c),
    .addr_in   (wr_gnt_c ? wr_addr : disp_addr),
    .ld_wr     (wr_gnt_c),
    .wdata_in  (wr_data),
    .be_in     (wr_be),
    .rd_valid  (disp_valid),
    .rd_data   (disp_data),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst, enable, disp_req, wr_req;
  logic [AW-1:0] disp_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_be;
  logic          disp_ready, disp_valid, wr_ready;
  logic [DW-1:0] disp_data;
  wire  [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  wire           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic          dq_probe, pin_probe;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_exp [4];
  int            total, bad, g;
  bit            got;

  always #10 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ready(disp_ready),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ready(wr_ready),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  // SRAM read drive; probe patterns show through only when the DUT releases the net
  assign sram_dq = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0 && sram_we_n === 1'b1) ?
                   mem[sram_addr] : (dq_probe ? 16'h5A5A : 16'hzzzz);
  assign sram_ce_n = pin_probe ? 1'b0 : 1'bz;
  assign sram_addr = pin_probe ? 20'h5A5A5 : 20'hzzzzz;

  // SRAM write commits on the rising edge of WE_N
  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0) begin
      if (sram_ub_n === 1'b0) mem[sram_addr][15:8] = sram_dq[15:8];
      if (sram_lb_n === 1'b0) mem[sram_addr][7:0]  = sram_dq[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  // Counts display grants from now until a write grant appears (bounded)
  task automatic count_grants(output int n, output bit wr_seen);
    n = 0;
    wr_seen = 1'b0;
    for (int i = 0; i < 20 && !wr_seen; i++) begin
      #1;
      if (wr_ready) wr_seen = 1'b1;
      else begin
        if (disp_ready) n++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; enable = 1'b1; disp_req = 1'b1; wr_req = 1'b1;
    disp_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    dq_probe = 1'b0; pin_probe = 1'b0;
    rd_exp = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    mem[20'h00280] = 16'hF81F;
    for (int i = 0; i < 4; i++) mem[i] = rd_exp[i];
    mem[20'h12345] = 16'h1234;

    // Reset with both requests high
    repeat (2) @(posedge clk);
    @(negedge clk);
    dq_probe = 1'b1;
    #1;
    chk("rst_ce_n", 32'(sram_ce_n), 32'h1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_ub_lb", 32'({sram_ub_n, sram_lb_n}), 32'h3);
    chk("rst_dq_z", 32'(sram_dq), 32'h5A5A);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_readies", 32'({disp_ready, wr_ready}), 32'h0);
    chk("rst_valid", 32'(disp_valid), 32'h0);
    chk("rst_data", 32'(disp_data), 32'h0);
    dq_probe = 1'b0;
    rst = 1'b0; disp_req = 1'b0; wr_req = 1'b0;

    // Single read of 0x00280
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 20'h00280;
    #1 chk("rd1_ready", 32'(disp_ready), 32'h1);
    @(negedge clk);
    chk("rd1_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h1);
    chk("rd1_addr", 32'(sram_addr), 32'h00280);
    chk("rd1_valid_early", 32'(disp_valid), 32'h0);
    disp_req = 1'b0;
    @(negedge clk);
    chk("rd1_valid", 32'(disp_valid), 32'h1);
    chk("rd1_data", 32'(disp_data), 32'hF81F);
    chk("rd1_oe_off", 32'(sram_oe_n), 32'h1);
    @(negedge clk);
    chk("rd1_valid_pulse", 32'(disp_valid), 32'h0);

    // Four back-to-back reads of 0..3
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        chk("burst_valid", 32'(disp_valid), 32'((k >= 2 && k <= 5) ? 1 : 0));
        if (k >= 2 && k <= 5) chk("burst_data", 32'(disp_data), 32'(rd_exp[k-2]));
      end
      if (k < 4) begin
        disp_req = 1'b1; disp_addr = AW'(k);
        #1 chk("burst_ready", 32'(disp_ready), 32'h1);
      end else begin
        disp_req = 1'b0;
      end
      @(negedge clk);
    end

    // Write 0xABCD to 0x12345, lower byte only, then read back straight after WR_HOLD
    wr_req = 1'b1; wr_addr = 20'h12345; wr_data = 16'hABCD; wr_be = 2'b01;
    #1;
    chk("wr_ready", 32'(wr_ready), 32'h1);
    chk("wr_disp_ready", 32'(disp_ready), 32'h0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      if (s == 0) wr_req = 1'b0;
      chk("wr_dq", 32'(sram_dq), 32'hABCD);
      chk("wr_ce_oe", 32'({sram_ce_n, sram_oe_n}), 32'h1);
      chk("wr_ub_lb", 32'({sram_ub_n, sram_lb_n}), 32'h2);
      chk("wr_we_n", 32'(sram_we_n), 32'((s == 1) ? 0 : 1));
      if (s == 2) begin
        disp_req = 1'b1; disp_addr = 20'h12345;
        #1 chk("rdaw_ready", 32'(disp_ready), 32'h1);
      end
    end
    @(negedge clk);
    disp_req = 1'b0;
    chk("rdaw_oe", 32'(sram_oe_n), 32'h0);
    chk("rdaw_dq_released", 32'(sram_dq), 32'h12CD);
    @(negedge clk);
    chk("rdaw_valid", 32'(disp_valid), 32'h1);
    chk("rdaw_data", 32'(disp_data), 32'h12CD);

    // Starvation guard: 8 display grants then the write
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 20'h00040;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 20'h00200; wr_data = 16'h5555; wr_be = 2'b11;
    count_grants(g, got);
    chk("starve1_grants", 32'(g), 32'd8);
    chk("starve1_wr", 32'(got), 32'h1);
    @(negedge clk);
    wr_req = 1'b0;
    #1 chk("starve_setup_ready", 32'({disp_ready, wr_ready}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    wr_req = 1'b1; wr_data = 16'h6666;
    count_grants(g, got);
    chk("starve2_grants", 32'(g), 32'd8);
    chk("starve2_wr", 32'(got), 32'h1);
    @(negedge clk);
    wr_req = 1'b0; disp_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("starve2_mem", 32'(mem[20'h00200]), 32'h6666);

    // Reset during a read: no valid pulse follows
    disp_req = 1'b1; disp_addr = 20'h00280;
    @(negedge clk);
    disp_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstrd_valid", 32'(disp_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstrd_valid2", 32'(disp_valid), 32'h0);

    // Reset during WR_PULSE
    wr_req = 1'b1; wr_addr = 20'h00300; wr_data = 16'h9999; wr_be = 2'b11;
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    chk("rstwr_pulse", 32'(sram_we_n), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    dq_probe = 1'b1;
    #1;
    chk("rstwr_we_n", 32'(sram_we_n), 32'h1);
    chk("rstwr_dq_z", 32'(sram_dq), 32'h5A5A);
    chk("rstwr_ce_n", 32'(sram_ce_n), 32'h1);
    dq_probe = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rstwr_idle", 32'({sram_ce_n, sram_we_n}), 32'h3);

    // Enable dropped during WR_SETUP: write completes, then pins release
    wr_req = 1'b1; wr_addr = 20'h00400; wr_data = 16'h7E7E; wr_be = 2'b11;
    @(negedge clk);
    wr_req = 1'b0; enable = 1'b0; disp_req = 1'b1; disp_addr = 20'h00280;
    chk("en_setup_ce", 32'(sram_ce_n), 32'h0);
    @(negedge clk);
    chk("en_pulse_we", 32'(sram_we_n), 32'h0);
    @(negedge clk);
    #1;
    chk("en_hold_we", 32'(sram_we_n), 32'h1);
    chk("en_hold_dq", 32'(sram_dq), 32'h7E7E);
    chk("en_hold_ready", 32'({disp_ready, wr_ready}), 32'h0);
    @(negedge clk);
    dq_probe = 1'b1; pin_probe = 1'b1;
    #1;
    chk("en_off_dq_z", 32'(sram_dq), 32'h5A5A);
    chk("en_off_ce_z", 32'(sram_ce_n), 32'h0);
    chk("en_off_addr_z", 32'(sram_addr), 32'h5A5A5);
    chk("en_off_ready", 32'({disp_ready, wr_ready}), 32'h0);
    chk("en_off_mem", 32'(mem[20'h00400]), 32'h7E7E);
    dq_probe = 1'b0; pin_probe = 1'b0; disp_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single asynchronous 16-bit pixel SRAM between two requesters: the display scan-out read port, which has real-time priority, and the trace/graticule write port fed by the HP859x capture logic. Drives the SRAM pins directly; sits between the framebuffer scan logic and the board SRAM. A starvation guard bounds write latency while scan-out is saturating the bus.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width (RGB565 pixel)
- STARVE_LIMIT, 8, consecutive display grants allowed while a write is pending
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  arbiter owns the SRAM pins; low releases them
- disp_req  in  1  display read request, held until accepted
- disp_addr  in  ADDR_W  display read address
- disp_ready  out  1  combinational; a transfer occurs on the edge where disp_req && disp_ready
- disp_valid  out  1  read data valid, one-cycle pulse per accepted read
- disp_data  out  DATA_W  read data, registered
- wr_req  in  1  write request, held until accepted
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  2  byte enables, [1] upper and [0] lower
- wr_ready  out  1  combinational write accept
- SRAM_ADDR  out  ADDR_W  registered address
- SRAM_DQ  inout  DATA_W  data bus; driven only during write states
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1  active-low controls, registered

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Decision cycles are IDLE, RD and WR_HOLD. Only in a decision cycle with enable=1 can disp_ready or wr_ready be 1, and never both at once.
- Priority in a decision cycle:
  - If starve_cnt == STARVE_LIMIT and wr_req=1, the write is granted.
  - Otherwise the display read is granted if disp_req=1.
  - Otherwise the write is granted if wr_req=1.
  - Otherwise the next state is IDLE.
- Read grant: the next state is RD and disp_addr is latched.
  - In RD: CE_N=0, OE_N=0, UB_N=0, LB_N=0, WE_N=1, DQ is Z.
- Write grant: WR_SETUP → WR_PULSE → WR_HOLD, and wr_addr, wr_data and wr_be are latched.
  - Across all three write states, CE_N=0, OE_N=1, DQ is driven, UB_N=~be[1] and LB_N=~be[0].
  - WE_N=0 only in WR_PULSE.
- starve_cnt (width covers STARVE_LIMIT):
  - Increments on each display grant while wr_req=1, saturating at STARVE_LIMIT.
  - Clears on a write grant, or in any cycle with wr_req=0.
- enable=0:
  - Sampled only in decision cycles, so an in-flight write completes.
  - Once the block is in IDLE with enable=0, SRAM_ADDR, all control pins and DQ are Z, and both ready outputs are 0.
- IDLE with enable=1: CE_N, OE_N, WE_N, UB_N and LB_N are all 1, and DQ is Z.

## Timing
- Reset values:
  - State IDLE, starve_cnt=0.
  - disp_valid=0, disp_data=0.
  - SRAM_ADDR=0.
  - CE_N, OE_N, WE_N, UB_N and LB_N all 1; DQ is Z.
- Read latency:
  - Accepted on the edge ending cycle N.
  - Pins present in cycle N+1; DQ is captured on the edge ending N+1.
  - disp_valid=1 in cycle N+2.
- Back-to-back reads sustain one per cycle (RD→RD).
- A write occupies 3 cycles. WR_HOLD is also a decision cycle, so the next transaction's pins appear in the cycle after WR_HOLD.
- A read directly after a write is permitted: DQ tri-states on the same edge that OE_N falls.
- Reset mid-operation, including during WR_PULSE: on the next edge WE_N=1 and DQ is Z, the state is IDLE, and no disp_valid is issued for a pending read.
- A simultaneous disp_req and wr_req with starve_cnt < STARVE_LIMIT grants the display.

## Structure
- Package sram_arb_pkg holds the state enum, the default ADDR_W and DATA_W, and the RGB565 field positions used by the scan logic.
- Sub-module sram_pin_drv:
  - Registers the address and control pins.
  - Owns the DQ tristate and output data register.
  - Registers the captured read data.
- The FSM, grant logic and starve_cnt stay in sram_arbiter.

## Test plan
- Reset with requests high: all controls read 1, DQ is Z, both ready outputs are 0, disp_valid=0.
- Single read of 0x00280, with the SRAM model holding 0xF81F: one RD cycle with OE_N=0, then disp_valid with data 0xF81F exactly 2 cycles after acceptance.
- Four continuous reads of 0x00000–0x00003: four consecutive disp_valid pulses with the matching model data, and no idle cycles.
- Write of 0xABCD to 0x12345 with be=2'b01: WE_N low for exactly 1 cycle, LB_N=0 and UB_N=1, DQ=0xABCD across all 3 write states. A read-back of 0x12345 returns the lower byte 0xCD updated and the upper byte unchanged.
- disp_req held high while wr_req rises: the write is granted after exactly 8 display grants, then reads resume and starve_cnt returns to 0.
- Two disruption cases:
  - rst asserted in WR_PULSE: the next cycle has WE_N=1, DQ is Z, and the state is IDLE.
  - enable dropped during WR_SETUP: the write completes, then all pins go to Z.
